// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   muldiv_op_t    operation encoding presented on the op port
//   muldiv_state_t control FSM states
//   MULDIV_WIDTH   default operand/result width
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_UMULH = 2'b01,
    OP_UDIV  = 2'b10,
    OP_SDIV  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } muldiv_state_t;

  localparam int MULDIV_WIDTH = 64;

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative WIDTH-bit multiply/divide execute unit placed after the
// register file. One request is accepted in IDLE, computed over WIDTH cycles
// (radix-2 shift-add multiply or restoring divide) and offered to writeback.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid, in_ready  request handshake (in_ready high only in IDLE)
//   op, A, B, dest      operation, operands, destination register index
//   out_valid,out_ready result handshake toward writeback
//   result, out_wa      register-file Writedata / wa3
//   RegWrite            out_valid & out_ready, register-file write enable
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH  = MULDIV_WIDTH,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic [REG_AW-1:0] dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic [REG_AW-1:0] out_wa,
  output logic              RegWrite
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  muldiv_state_t      state;
  muldiv_op_t         op_q;
  logic [2*WIDTH-1:0] acc;    // {product hi, multiplier} or {remainder, dividend/quotient}
  logic [WIDTH-1:0]   opnd;   // multiplicand or divisor
  logic [CNT_W-1:0]   cnt;
  logic               neg_q;

  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   final_res;
  logic               last;
  logic               is_div;
  logic               div_zero;
  muldiv_op_t         op_in;

  // Shift-add step: add multiplicand into the high half when the current
  // multiplier bit is set, then shift the whole product right, keeping the carry.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p,
                                                  input logic [WIDTH-1:0]   m);
    logic [WIDTH:0] sum;
    sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
    return {sum, p[WIDTH-1:1]};
  endfunction

  // Restoring step: shift the next dividend bit into the remainder and subtract
  // the divisor; a borrow out of the extra top bit means the subtraction is undone.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] p,
                                                  input logic [WIDTH-1:0]   d);
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;
    rem_sh = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    diff   = rem_sh - {1'b0, d};
    if (diff[WIDTH]) return {rem_sh[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
    else             return {diff[WIDTH-1:0],   p[WIDTH-2:0], 1'b1};
  endfunction

  // Magnitude modulo 2^WIDTH; the most negative value maps onto itself, which
  // as an unsigned number is exactly its magnitude.
  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] r;
    r = v[WIDTH-1] ? -v : v;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] sel_result(input muldiv_op_t         o,
                                                  input logic [2*WIDTH-1:0] prod,
                                                  input logic [2*WIDTH-1:0] quo,
                                                  input logic               neg);
    logic signed [WIDTH-1:0] q;
    q = quo[WIDTH-1:0];
    case (o)
      OP_MUL:   return prod[WIDTH-1:0];
      OP_UMULH: return prod[2*WIDTH-1:WIDTH];
      OP_UDIV:  return quo[WIDTH-1:0];
      default:  return neg ? -q : q;
    endcase
  endfunction

  always_comb begin
    op_in     = muldiv_op_t'(op);
    is_div    = (op_in == OP_UDIV) || (op_in == OP_SDIV);
    div_zero  = is_div && (B == '0);
    mul_next  = mul_step(acc, opnd);
    div_next  = div_step(acc, opnd);
    last      = (cnt == CNT_W'(WIDTH - 1));
    final_res = sel_result(op_q, mul_next, div_next, neg_q);
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign RegWrite  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      op_q   <= OP_MUL;
      acc    <= '0;
      opnd   <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      result <= '0;
      out_wa <= '0;
    end else begin
      case (state)
        // Accept: latch request and seed the datapath
        S_IDLE: begin
          if (in_valid) begin
            op_q   <= op_in;
            out_wa <= dest;
            cnt    <= '0;
            neg_q  <= 1'b0;
            if (div_zero) begin
              result <= '0;
              state  <= S_DONE;
            end else begin
              state <= S_CALC;
              case (op_in)
                OP_MUL, OP_UMULH: begin
                  opnd <= A;
                  acc  <= {{WIDTH{1'b0}}, B};
                end
                OP_UDIV: begin
                  opnd <= B;
                  acc  <= {{WIDTH{1'b0}}, A};
                end
                default: begin
                  opnd  <= abs_val(B);
                  acc   <= {{WIDTH{1'b0}}, abs_val(A)};
                  neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
                end
              endcase
            end
          end
        end
        // Iterate: one product/quotient bit per cycle, result registered on the last
        S_CALC: begin
          acc <= op_q[1] ? div_next : mul_next;
          cnt <= cnt + 1'b1;
          if (last) begin
            result <= final_res;
            state  <= S_DONE;
          end
        end
        // Offer: hold result until writeback takes it
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
